// File: rtl/dma_word_copy.sv
// dma_word_copy: bus initiator that moves a block of 32-bit words between two byte addresses.
// Define DMA_FILL_MODE_EN to add the fill/pattern inputs for constant-pattern block writes.
module dma_word_copy #(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef DMA_FILL_MODE_EN
  input  logic             fill,
  input  logic [31:0]      pattern,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nx_s;
  logic [LEN_W-1:0] cnt_r, cnt_nx_s;
  logic [LEN_W-1:0] len_r, len_nx_s;
  logic [31:0]      src_r, src_nx_s;
  logic [31:0]      dst_r, dst_nx_s;
  logic [31:0]      data_r, data_nx_s;
  logic             fill_r, fill_nx_s;
  logic [31:0]      pattern_r, pattern_nx_s;
  logic             err_nx_s;
  logic             fill_in_s;
  logic [31:0]      pattern_in_s;
  logic [31:0]      offset_s;
  logic [31:0]      mem_a_s;
  logic [31:0]      mem_wd_s;

`ifdef DMA_FILL_MODE_EN
  assign fill_in_s    = fill;
  assign pattern_in_s = pattern;
`else
  assign fill_in_s    = 1'b0;
  assign pattern_in_s = 32'h0000_0000;
`endif

  // Next-state logic; bus outputs are derived from the next state so they can be registered.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    len_nx_s     = len_r;
    src_nx_s     = src_r;
    dst_nx_s     = dst_r;
    data_nx_s    = data_r;
    fill_nx_s    = fill_r;
    pattern_nx_s = pattern_r;
    err_nx_s     = err;
    offset_s     = 32'h0000_0000;
    mem_a_s      = 32'h0000_0000;
    mem_wd_s     = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          src_nx_s     = src_addr;
          dst_nx_s     = dst_addr;
          len_nx_s     = len;
          fill_nx_s    = fill_in_s;
          pattern_nx_s = pattern_in_s;
          cnt_nx_s     = CNT_ZERO;
          err_nx_s     = 1'b0;
          // Fill mode never reads, so only the destination alignment matters there.
          if ((dst_addr[1:0] != 2'b00) || (!fill_in_s && (src_addr[1:0] != 2'b00))) begin
            err_nx_s   = 1'b1;
            state_nx_s = ST_DONE;
          end else if (len == CNT_ZERO) begin
            state_nx_s = ST_DONE;
          end else if (fill_in_s) begin
            state_nx_s = ST_WRITE;
          end else begin
            state_nx_s = ST_READ;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_READ: begin
        data_nx_s  = mem_rd;
        state_nx_s = ST_WRITE;
      end
      ST_WRITE: begin
        cnt_nx_s = cnt_r + CNT_ONE;
        if (cnt_nx_s == len_r) begin
          state_nx_s = ST_DONE;
        end else if (fill_r) begin
          state_nx_s = ST_WRITE;
        end else begin
          state_nx_s = ST_READ;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    offset_s = 32'({cnt_nx_s, 2'b00});
    case (state_nx_s)
      ST_READ: begin
        mem_a_s = src_nx_s + offset_s;
      end
      ST_WRITE: begin
        mem_a_s  = dst_nx_s + offset_s;
        mem_wd_s = fill_nx_s ? pattern_nx_s : data_nx_s;
      end
      default: begin
        mem_a_s  = 32'h0000_0000;
        mem_wd_s = 32'h0000_0000;
      end
    endcase
  end

  // State, transfer context and registered bus/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      len_r     <= CNT_ZERO;
      src_r     <= 32'h0000_0000;
      dst_r     <= 32'h0000_0000;
      data_r    <= 32'h0000_0000;
      fill_r    <= 1'b0;
      pattern_r <= 32'h0000_0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= 32'h0000_0000;
      mem_wd    <= 32'h0000_0000;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      len_r     <= len_nx_s;
      src_r     <= src_nx_s;
      dst_r     <= dst_nx_s;
      data_r    <= data_nx_s;
      fill_r    <= fill_nx_s;
      pattern_r <= pattern_nx_s;
      busy      <= (state_nx_s == ST_READ) || (state_nx_s == ST_WRITE);
      done      <= (state_nx_s == ST_DONE);
      err       <= err_nx_s;
      mem_we    <= (state_nx_s == ST_WRITE);
      mem_a     <= mem_a_s;
      mem_wd    <= mem_wd_s;
    end
  end

endmodule
